// File: rtl/icache_dm_resp.sv
// Direct-mapped instruction responder between IF and the BIU: one 64-bit doubleword per line,
// with a single outstanding refill. Define ICACHE_PERF_EN to add the hit/miss counters.
module icache_dm_resp #(
  parameter int IDX_W   = 4,
  parameter int PADDR_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PADDR_W-1:0] addr,
  input  logic               rd,
  input  logic [3:0]         if_priv,
  input  logic               cache_flush,
  output logic [63:0]        ins_read,
  output logic               cache_ready,
  output logic               ins_acc_fault,
  output logic               ins_page_fault,
  output logic               bus_req,
  output logic [PADDR_W-1:0] bus_addr,
  output logic [3:0]         bus_priv,
  input  logic               bus_ack,
  input  logic [63:0]        bus_data,
  input  logic               bus_acc_fault,
  input  logic               bus_page_fault,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = PADDR_W - IDX_W - 3;
  localparam int LA_W  = PADDR_W - 3;

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [LA_W-1:0]  line_addr;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [63:0]      data_mem [LINES];

  logic             rec_valid;
  logic [LA_W-1:0]  rec_addr;
  logic             rec_acc;
  logic             rec_page;
  logic             drop;

  logic             hit;
  logic             rec_hit;
  logic             miss;
  logic             ack_fault;
  logic             discard;
  logic             install;

  logic             unused_addr_lsbs;

  assign idx       = addr[IDX_W+2:3];
  assign tag       = addr[PADDR_W-1:IDX_W+3];
  assign line_addr = addr[PADDR_W-1:3];
  assign fill_idx  = bus_addr[IDX_W+2:3];
  assign fill_tag  = bus_addr[PADDR_W-1:IDX_W+3];
  assign ack_fault = bus_acc_fault | bus_page_fault;
  // A flush arriving with the ack still kills the returning line.
  assign discard   = drop | cache_flush;
  assign unused_addr_lsbs = ^{addr[2:0], bus_addr[2:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state and the same-cycle fetch response
  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_next     = state;
    hit            = 1'b0;
    rec_hit        = 1'b0;
    miss           = 1'b0;
    install        = 1'b0;
    cache_ready    = 1'b0;
    ins_acc_fault  = 1'b0;
    ins_page_fault = 1'b0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          if (rd) begin
            if (!cache_flush && valid[idx] && (tag_mem[idx] == tag)) begin
              hit = 1'b1;
            end else if (!cache_flush && rec_valid && (line_addr == rec_addr)) begin
              rec_hit = 1'b1;
            end else begin
              miss       = 1'b1;
              state_next = S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (bus_ack) begin
            install    = !discard && !ack_fault;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
    cache_ready    = hit | rec_hit;
    ins_acc_fault  = rec_hit & rec_acc;
    ins_page_fault = rec_hit & rec_page;
  end

  // Control registers: valid bits, fault record, refill request and returned doubleword
  // NOTE: sequential state uses non-blocking assignments only, so later statements win cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      ins_read  <= '0;
      bus_req   <= 1'b0;
      bus_addr  <= '0;
      bus_priv  <= '0;
      rec_valid <= 1'b0;
      rec_addr  <= '0;
      rec_acc   <= 1'b0;
      rec_page  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cache_flush) begin
            valid     <= '0;
            rec_valid <= 1'b0;
          end
          if (hit) ins_read <= data_mem[idx];
          if (rec_hit) begin
            ins_read  <= '0;
            rec_valid <= 1'b0;
          end
          if (miss) begin
            rec_valid <= 1'b0;
            bus_req   <= 1'b1;
            bus_addr  <= {line_addr, 3'b000};
            bus_priv  <= if_priv;
          end
        end
        S_REFILL: begin
          if (cache_flush) begin
            valid <= '0;
            drop  <= 1'b1;
          end
          if (bus_ack) begin
            bus_req <= 1'b0;
            drop    <= 1'b0;
            if (!discard && ack_fault) begin
              rec_valid <= 1'b1;
              rec_addr  <= bus_addr[PADDR_W-1:3];
              rec_acc   <= bus_acc_fault;
              rec_page  <= bus_page_fault;
            end
            if (install) valid[fill_idx] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag/data storage is not reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus_data;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_dm_resp.sv
// Bench for icache_dm_resp: directed walk through the main scenarios, then randomized traffic
// with a random-latency BIU, all compared against a line-array reference model.
module tb_icache_dm_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] addr;
  logic        rd;
  logic [3:0]  if_priv;
  logic        cache_flush;
  logic [63:0] ins_read;
  logic        cache_ready;
  logic        ins_acc_fault;
  logic        ins_page_fault;
  logic        bus_req;
  logic [63:0] bus_addr;
  logic [3:0]  bus_priv;
  logic        bus_ack;
  logic [63:0] bus_data;
  logic        bus_acc_fault;
  logic        bus_page_fault;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always #5 clk = ~clk;

  icache_dm_resp #(.IDX_W(4), .PADDR_W(64)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd(rd), .if_priv(if_priv), .cache_flush(cache_flush),
    .ins_read(ins_read), .cache_ready(cache_ready), .ins_acc_fault(ins_acc_fault),
    .ins_page_fault(ins_page_fault), .bus_req(bus_req), .bus_addr(bus_addr), .bus_priv(bus_priv),
    .bus_ack(bus_ack), .bus_data(bus_data), .bus_acc_fault(bus_acc_fault),
    .bus_page_fault(bus_page_fault), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Reference model: per-line contents, pending refill, fault record
  bit          m_refill, m_drop, m_breq;
  bit          m_valid [16];
  logic [56:0] m_tag   [16];
  logic [63:0] m_data  [16];
  bit          m_rec_v, m_rec_acc, m_rec_pg;
  logic [60:0] m_rec_a;
  logic [63:0] m_ins, m_baddr;
  logic [3:0]  m_bpriv;
  logic [31:0] m_hits, m_misses;

  function automatic void model_reset();
    m_refill = 0; m_drop = 0; m_breq = 0;
    foreach (m_valid[i]) m_valid[i] = 0;
    m_rec_v = 0; m_rec_acc = 0; m_rec_pg = 0; m_rec_a = '0;
    m_ins = '0; m_baddr = '0; m_bpriv = '0;
    m_hits = '0; m_misses = '0;
  endfunction

  // One clock: drive inputs, check the same-cycle response, advance the model, check registers.
  task automatic step(input logic i_rst, input logic i_rd, input logic [63:0] i_addr,
                      input logic i_flush, input logic i_ack, input logic [63:0] i_data,
                      input logic i_af, input logic i_pf, input logic [3:0] i_priv);
    int          kind;
    logic [3:0]  li;
    logic [56:0] lt;
    logic [2:0]  e_resp;
    rst = i_rst; rd = i_rd; addr = i_addr; cache_flush = i_flush; if_priv = i_priv;
    bus_ack = i_ack; bus_data = i_data; bus_acc_fault = i_af; bus_page_fault = i_pf;
    #1;
    li   = i_addr[6:3];
    lt   = i_addr[63:7];
    kind = 0;
    if (!i_rst && !m_refill && i_rd) begin
      if (!i_flush && m_valid[li] && m_tag[li] == lt)           kind = 1;
      else if (!i_flush && m_rec_v && m_rec_a == i_addr[63:3])  kind = 2;
      else                                                      kind = 3;
    end
    e_resp = {kind == 1 || kind == 2, kind == 2 && m_rec_acc, kind == 2 && m_rec_pg};
    check("resp{ready,acc,page}", {61'd0, cache_ready, ins_acc_fault, ins_page_fault},
          {61'd0, e_resp});

    if (i_rst) begin
      model_reset();
    end else if (!m_refill) begin
      if (i_flush) begin
        foreach (m_valid[i]) m_valid[i] = 0;
        m_rec_v = 0;
      end
      case (kind)
        1: begin m_ins = m_data[li]; m_hits++; end
        2: begin m_ins = '0; m_rec_v = 0; end
        3: begin
          m_rec_v = 0; m_breq = 1; m_refill = 1; m_misses++;
          m_baddr = {i_addr[63:3], 3'b000}; m_bpriv = i_priv;
        end
        default: ;
      endcase
    end else begin
      if (i_flush) begin
        foreach (m_valid[i]) m_valid[i] = 0;
        m_drop = 1;
      end
      if (i_ack) begin
        if (!m_drop) begin
          if (i_af || i_pf) begin
            m_rec_v = 1; m_rec_a = m_baddr[63:3]; m_rec_acc = i_af; m_rec_pg = i_pf;
          end else begin
            m_valid[m_baddr[6:3]] = 1;
            m_tag[m_baddr[6:3]]   = m_baddr[63:7];
            m_data[m_baddr[6:3]]  = i_data;
          end
        end
        m_breq = 0; m_refill = 0; m_drop = 0;
      end
    end

    @(posedge clk);
    #1;
    check("ins_read", ins_read, m_ins);
    check("bus_req", {63'd0, bus_req}, {63'd0, m_breq});
    check("bus_addr", bus_addr, m_baddr);
    check("bus_priv", {60'd0, bus_priv}, {60'd0, m_bpriv});
`ifdef ICACHE_PERF_EN
    check("hit_cnt", {32'd0, hit_cnt}, {32'd0, m_hits});
    check("miss_cnt", {32'd0, miss_cnt}, {32'd0, m_misses});
`else
    check("hit_cnt", {32'd0, hit_cnt}, 64'd0);
    check("miss_cnt", {32'd0, miss_cnt}, 64'd0);
`endif
  endtask

  task automatic fetch(input logic [63:0] a);
    step(0, 1, a, 0, 0, '0, 0, 0, 4'h3);
  endtask

  task automatic ack(input logic i_rd, input logic [63:0] a, input logic [63:0] d,
                     input logic af, input logic pf);
    step(0, i_rd, a, 0, 1, d, af, pf, 4'h3);
  endtask

  localparam logic [63:0] INSN = 64'h0000_0013_0010_0093;

  logic [56:0] tag_pool [3];
  logic [63:0] ra;
  logic        r_ack, r_af, r_pf;

  initial begin
    model_reset();
    step(1, 0, '0, 0, 0, '0, 0, 0, 4'h0);
    step(1, 0, '0, 0, 0, '0, 0, 0, 4'h0);

    // Cold miss, BIU acks after three cycles, then hits
    fetch(64'h1000);
    check("tp_cold_req", {63'd0, bus_req}, 64'd1);
    check("tp_cold_addr", bus_addr, 64'h1000);
    fetch(64'h1000);
    fetch(64'h1000);
    ack(1, 64'h1000, INSN, 0, 0);
    fetch(64'h1000);
    check("tp_cold_data", ins_read, INSN);
    fetch(64'h1004);
    check("tp_hit_noreq", {63'd0, bus_req}, 64'd0);

    // Page fault is reported once, then the fetch re-requests
    fetch(64'h2000);
    ack(1, 64'h2000, 64'hdead_beef_0000_0001, 0, 1);
    fetch(64'h2000);
    check("tp_fault_data", ins_read, 64'd0);
    fetch(64'h2000);
    check("tp_fault_rereq", {63'd0, bus_req}, 64'd1);
    ack(1, 64'h2000, 64'h1111_2222_3333_4444, 0, 0);

    // Conflict eviction on index 0
    fetch(64'h1080);
    ack(1, 64'h1080, 64'h5555_6666_7777_8888, 0, 0);
    fetch(64'h1000);
    check("tp_evict_addr", bus_addr, 64'h1000);
    ack(1, 64'h1000, INSN, 0, 0);

    // Flush during refill drops the line and all earlier ones
    fetch(64'h3000);
    step(0, 1, 64'h3000, 1, 0, '0, 0, 0, 4'h3);
    ack(1, 64'h3000, 64'h9999_aaaa_bbbb_cccc, 0, 0);
    fetch(64'h3000);
    check("tp_flush_rereq", bus_addr, 64'h3000);
    ack(1, 64'h3000, 64'h9999_aaaa_bbbb_cccc, 0, 0);
    fetch(64'h1000);
    check("tp_flush_old_miss", {63'd0, bus_req}, 64'd1);
    ack(1, 64'h1000, INSN, 0, 0);

    // rd dropped during refill: silent install, later hit
    fetch(64'h3008);
    step(0, 0, 64'h0, 0, 0, '0, 0, 0, 4'h3);
    ack(0, 64'h0, 64'h0123_4567_89ab_cdef, 0, 0);
    fetch(64'h3008);
    check("tp_drop_hit", ins_read, 64'h0123_4567_89ab_cdef);

    // Randomized traffic with a random-latency BIU and occasional stray acks/resets
    tag_pool[0] = 57'h20;
    tag_pool[1] = 57'h21;
    tag_pool[2] = 57'h1_2345_6789_abcd;
    for (int n = 0; n < 3000; n++) begin
      ra = {tag_pool[$urandom_range(2)], 4'($urandom_range(3)), 3'($urandom_range(7))};
      r_ack = m_breq ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      r_af  = ($urandom_range(9) == 0);
      r_pf  = ($urandom_range(9) == 0);
      step($urandom_range(199) == 0, $urandom_range(3) != 0, ra, $urandom_range(24) == 0,
           r_ack, {$urandom, $urandom}, r_af, r_pf, 4'($urandom_range(15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
